// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: register/bus widths, register word type and one-hot select helpers.
// Pure declarations, no timing; no flow control.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int NREGS  = 16;

  typedef logic [DATA_W-1:0] reg_word_t;
  typedef logic [NREGS-1:0]  sel_t;

  // A vector with its lowest set bit removed is zero exactly when at most one bit was set.
  function automatic logic is_onehot(input sel_t v);
    return (v != '0) && ((v & (v - sel_t'(1))) == '0);
  endfunction

  function automatic logic is_multihot(input sel_t v);
    return (v & (v - sel_t'(1))) != '0;
  endfunction

endpackage

// File: rtl/onehot_check.sv
// Classifies a register-select vector as none / exactly-one / multi-hot.
// Combinational, zero latency; no flow control.
module onehot_check
  import cpu_pkg::*;
(
  input  logic [NREGS-1:0] vec,
  output logic             none,
  output logic             one,
  output logic             multi
);

  always_comb begin
    none  = (vec == '0);
    one   = is_onehot(vec);
    multi = is_multihot(vec);
  end

endmodule

// File: rtl/reg_file_onehot.sv
// Sixteen-entry register file addressed by one-hot decoder selects, with R0-as-zero and sticky select error.
// Write 1 edge, read combinational; no backpressure. Optional write-through via REGFILE_BYPASS_EN.
module reg_file_onehot #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int NREGS  = cpu_pkg::NREGS
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [NREGS-1:0]  rin_onehot,
  input  logic [NREGS-1:0]  rout_onehot,
  input  logic              ba_out,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              rout_valid,
  output logic              sel_err,
  input  logic              err_clr
);

  logic [DATA_W-1:0] regs [NREGS];
  logic              rin_none, rin_one, rin_multi;
  logic              rout_none, rout_one, rout_multi;
  logic [DATA_W-1:0] rd_data;

  onehot_check u_rin_check (
    .vec   (rin_onehot),
    .none  (rin_none),
    .one   (rin_one),
    .multi (rin_multi)
  );

  onehot_check u_rout_check (
    .vec   (rout_onehot),
    .none  (rout_none),
    .one   (rout_one),
    .multi (rout_multi)
  );

  // A multi-hot write is rejected as a whole, so only a legal one-hot select writes.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (rin_one) begin
      for (int i = 0; i < NREGS; i++) begin
        if (rin_onehot[i]) regs[i] <= bus_in;
      end
    end
  end

  // New error wins over err_clr in the same cycle.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      sel_err <= 1'b0;
    end else if (rin_multi || rout_multi) begin
      sel_err <= 1'b1;
    end else if (err_clr) begin
      sel_err <= 1'b0;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rout_one) begin
      for (int i = 0; i < NREGS; i++) begin
        if (rout_onehot[i]) rd_data = regs[i];
      end
`ifdef REGFILE_BYPASS_EN
      if (rin_one && (rin_onehot == rout_onehot)) rd_data = bus_in;
`endif
      if (rout_onehot[0] && ba_out) rd_data = '0;
    end
  end

  assign bus_out    = rd_data;
  assign rout_valid = rout_one && !rout_none;

endmodule

// File: tb/tb_reg_file_onehot.sv
// Directed bench for reg_file_onehot: array model checked every cycle plus literal spot checks.
module tb_reg_file_onehot;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [15:0] rin_onehot = '0;
  logic [15:0] rout_onehot = '0;
  logic        ba_out = 1'b0;
  logic [31:0] bus_in = '0;
  logic [31:0] bus_out;
  logic        rout_valid;
  logic        sel_err;
  logic        err_clr = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [16];
  logic        model_err;

  reg_file_onehot dut (
    .clock       (clock),
    .clear       (clear),
    .rin_onehot  (rin_onehot),
    .rout_onehot (rout_onehot),
    .ba_out      (ba_out),
    .bus_in      (bus_in),
    .bus_out     (bus_out),
    .rout_valid  (rout_valid),
    .sel_err     (sel_err),
    .err_clr     (err_clr)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sel_index(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] exp_bus();
    int idx;
    if ($countones(rout_onehot) != 1) return 32'h0;
    idx = sel_index(rout_onehot);
    if (idx == 0 && ba_out) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (rin_onehot == rout_onehot) return bus_in;
`endif
    return model[idx];
  endfunction

  // Reference model: registers as a plain array updated from the select population count.
  always @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) model[i] = 32'h0;
      model_err = 1'b0;
    end else begin
      if ($countones(rin_onehot) == 1) model[sel_index(rin_onehot)] = bus_in;
      if ($countones(rin_onehot) > 1 || $countones(rout_onehot) > 1) model_err = 1'b1;
      else if (err_clr) model_err = 1'b0;
    end
  end

  always @(negedge clock) begin
    check("model_bus_out", bus_out, exp_bus());
    check("model_rout_valid", {31'h0, rout_valid}, {31'h0, $countones(rout_onehot) == 1});
    check("model_sel_err", {31'h0, sel_err}, {31'h0, model_err});
  end

  task automatic step(input logic [15:0] rin, input logic [15:0] rout, input logic ba,
                      input logic [31:0] din, input logic eclr);
    @(posedge clock);
    #2;
    rin_onehot  = rin;
    rout_onehot = rout;
    ba_out      = ba;
    bus_in      = din;
    err_clr     = eclr;
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #3;
    check("reset_bus_out", bus_out, 32'h0);
    check("reset_sel_err", {31'h0, sel_err}, 32'h0);
    clear = 1'b0;

    step(16'h0020, 16'h0000, 1'b0, 32'hDEADBEEF, 1'b0);
    step(16'h0000, 16'h0020, 1'b0, 32'h0, 1'b0);
    check("rd_r5", bus_out, 32'hDEADBEEF);
    check("rd_r5_valid", {31'h0, rout_valid}, 32'h1);

    step(16'h0001, 16'h0000, 1'b0, 32'h00000044, 1'b0);
    step(16'h0000, 16'h0001, 1'b0, 32'h0, 1'b0);
    check("rd_r0", bus_out, 32'h44);
    step(16'h0000, 16'h0001, 1'b1, 32'h0, 1'b0);
    check("rd_r0_ba", bus_out, 32'h0);
    check("rd_r0_ba_valid", {31'h0, rout_valid}, 32'h1);
    step(16'h0000, 16'h0001, 1'b0, 32'h0, 1'b0);
    check("rd_r0_after_ba", bus_out, 32'h44);

    step(16'h0008, 16'h0000, 1'b0, 32'h00000033, 1'b0);
    step(16'h0009, 16'h0000, 1'b0, 32'h12345678, 1'b0);
    check("multi_wr_err_not_yet", {31'h0, sel_err}, 32'h0);
    step(16'h0000, 16'h0001, 1'b0, 32'h0, 1'b0);
    check("multi_wr_r0", bus_out, 32'h44);
    check("multi_wr_err", {31'h0, sel_err}, 32'h1);
    step(16'h0000, 16'h0008, 1'b0, 32'h0, 1'b0);
    check("multi_wr_r3", bus_out, 32'h33);

    step(16'h0000, 16'h0300, 1'b0, 32'h0, 1'b1);
    check("multi_rd_bus", bus_out, 32'h0);
    check("multi_rd_valid", {31'h0, rout_valid}, 32'h0);
    step(16'h0000, 16'h0020, 1'b0, 32'h0, 1'b1);
    check("clr_race_err", {31'h0, sel_err}, 32'h1);
    step(16'h0000, 16'h0000, 1'b0, 32'h0, 1'b0);
    check("clr_done_err", {31'h0, sel_err}, 32'h0);

    step(16'h8000, 16'h0000, 1'b0, 32'h00000001, 1'b0);
    step(16'h8000, 16'h8000, 1'b0, 32'hA5A5A5A5, 1'b0);
`ifdef REGFILE_BYPASS_EN
    check("same_reg_rw", bus_out, 32'hA5A5A5A5);
`else
    check("same_reg_rw", bus_out, 32'h00000001);
`endif
    step(16'h0000, 16'h8000, 1'b0, 32'h0, 1'b0);
    check("same_reg_after", bus_out, 32'hA5A5A5A5);

    step(16'h0002, 16'h0020, 1'b0, 32'h00000077, 1'b0);
    check("diff_reg_rw", bus_out, 32'hDEADBEEF);
    step(16'h0000, 16'h0002, 1'b0, 32'h0, 1'b0);
    check("diff_reg_after", bus_out, 32'h77);
    step(16'h0001, 16'h0001, 1'b1, 32'h00000099, 1'b0);
    check("ba_over_write", bus_out, 32'h0);

    for (int i = 0; i < 16; i++) begin
      logic [15:0] s;
      s = 16'h1 << i;
      step(s, 16'h0000, 1'b0, 32'h01010101 * (i + 1), 1'b0);
    end
    for (int i = 0; i < 16; i++) begin
      logic [15:0] s;
      s = 16'h1 << i;
      step(16'h0000, s, 1'b0, 32'h0, 1'b0);
      check("sweep_rd", bus_out, 32'h01010101 * (i + 1));
    end

    step(16'h0000, 16'h0011, 1'b0, 32'h0, 1'b0);
    step(16'h0004, 16'h0020, 1'b0, 32'hFFFFFFFF, 1'b0);
    check("pre_clear_err", {31'h0, sel_err}, 32'h1);
    clear = 1'b1;
    #1;
    check("clear_bus", bus_out, 32'h0);
    check("clear_err", {31'h0, sel_err}, 32'h0);
    @(posedge clock);
    #2;
    clear = 1'b0;
    rin_onehot = 16'h0;
    for (int i = 0; i < 16; i++) begin
      logic [15:0] s;
      s = 16'h1 << i;
      step(16'h0000, s, 1'b0, 32'h0, 1'b0);
      check("post_clear_rd", bus_out, 32'h0);
    end
    check("post_clear_err", {31'h0, sel_err}, 32'h0);

    @(posedge clock);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
